// File: rtl/hmac_ctrl_slave.sv
// rtl/hmac_ctrl_slave.sv - AXI4-Lite register slave controlling the HMAC core
//
// Purpose:
//   Register file for the HMAC engine. It holds the 256-bit key and the
//   message length, reports core status, and issues start/clear command pulses.
//   When the optional statistics block is built, it also counts packets and bytes.
//
// Configuration:
//   HMAC_CTRL_STATS_EN - when defined, builds PKT_CNT (32-bit) and BYTE_CNT (64-bit).
//                        When undefined, those addresses answer SLVERR, and
//                        pkt_done_i/pkt_bytes_i are ignored.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axil_aw*            write address channel (addr, valid, ready)
//   s_axil_w*             write data channel (data, strb, valid, ready)
//   s_axil_b*             write response channel (resp, valid, ready)
//   s_axil_ar*            read address channel (addr, valid, ready)
//   s_axil_r*             read data channel (data, resp, valid, ready)
//   ctrl_start/ctrl_clear one-cycle command pulses to the core
//   key_o, len_o          key {KEY3,KEY2,KEY1,KEY0} and message length
//   busy_i, done_i        core status; done_i is a one-cycle pulse
//   pkt_done_i, pkt_bytes_i  packet-complete pulse and its byte count
//
// Register map (8-byte aligned, address bits [2:0] ignored):
//   0x00 CTRL (WO)  0x08 STATUS (RO)  0x10-0x28 KEY0..KEY3 (RW)
//   0x30 LEN (RW)   0x38 PKT_CNT (RO) 0x40 BYTE_CNT (RO)
module hmac_ctrl_slave #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 64
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ADDR_BITS-1:0]   s_axil_awaddr,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [DATA_BITS-1:0]   s_axil_wdata,
    input  logic [DATA_BITS/8-1:0] s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_BITS-1:0]   s_axil_araddr,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [DATA_BITS-1:0]   s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic                   ctrl_start,
    output logic                   ctrl_clear,
    output logic [255:0]           key_o,
    output logic [31:0]            len_o,
    input  logic                   busy_i,
    input  logic                   done_i,
    input  logic                   pkt_done_i,
    input  logic [15:0]            pkt_bytes_i
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int WORD_BITS = ADDR_BITS - 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] SEL_CTRL   = 4'd0;
    localparam logic [3:0] SEL_STATUS = 4'd1;
    localparam logic [3:0] SEL_KEY0   = 4'd2;
    localparam logic [3:0] SEL_KEY1   = 4'd3;
    localparam logic [3:0] SEL_KEY2   = 4'd4;
    localparam logic [3:0] SEL_KEY3   = 4'd5;
    localparam logic [3:0] SEL_LEN    = 4'd6;
    localparam logic [3:0] SEL_PKT    = 4'd7;
    localparam logic [3:0] SEL_BCNT   = 4'd8;
    localparam logic [3:0] SEL_NONE   = 4'd15;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
    typedef enum logic { R_IDLE,  R_DATA  } rd_state_e;

    // The word index (byte address / 8) selects a register directly; anything
    // past the last implemented word maps to SEL_NONE.
    function automatic logic [3:0] decode(input logic [WORD_BITS-1:0] word);
        logic [3:0] sel;
        sel = SEL_NONE;
        if (word <= WORD_BITS'(8)) begin
            sel = word[3:0];
        end
`ifndef HMAC_CTRL_STATS_EN
        if (sel == SEL_PKT || sel == SEL_BCNT) begin
            sel = SEL_NONE;
        end
`endif
        return sel;
    endfunction

    function automatic logic [DATA_BITS-1:0] merge_bytes(
        input logic [DATA_BITS-1:0] old_val,
        input logic [DATA_BITS-1:0] new_val,
        input logic [STRB_BITS-1:0] strb
    );
        logic [DATA_BITS-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_BITS; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Write path state
    wr_state_e                 wr_state_q, wr_state_d;
    logic                      aw_held_q, aw_held_d;
    logic [WORD_BITS-1:0]      aw_word_q, aw_word_d;
    logic                      w_held_q, w_held_d;
    logic [DATA_BITS-1:0]      w_data_q, w_data_d;
    logic [STRB_BITS-1:0]      w_strb_q, w_strb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      ctrl_start_q, ctrl_start_d;
    logic                      ctrl_clear_q, ctrl_clear_d;
    logic [3:0][DATA_BITS-1:0] key_q, key_d;
    logic [31:0]               len_q, len_d;
    logic [3:0]                wr_sel;

    // Read path state
    rd_state_e                 rd_state_q, rd_state_d;
    logic                      arready_q, arready_d;
    logic [DATA_BITS-1:0]      rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [3:0]                rd_sel_q, rd_sel_d;
    logic                      done_q, done_d;
    logic [3:0]                ar_sel;
    logic                      status_rd_done;

`ifdef HMAC_CTRL_STATS_EN
    logic [31:0]               pkt_cnt_q, pkt_cnt_d;
    logic [63:0]               byte_cnt_q, byte_cnt_d;
`endif

    // Byte-lane offset bits are never decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[2:0], s_axil_araddr[2:0]};

    // ------------------------------------------------------------------
    // Write FSM: collect AW and W independently, commit once both are held,
    // then hold off new requests until the B handshake.
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d   = wr_state_q;
        aw_held_d    = aw_held_q;
        aw_word_d    = aw_word_q;
        w_held_d     = w_held_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bresp_d      = bresp_q;
        ctrl_start_d = 1'b0;
        ctrl_clear_d = 1'b0;
        key_d        = key_q;
        len_d        = len_q;
        wr_sel       = decode(aw_word_q);

        if (s_axil_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_word_d = s_axil_awaddr[ADDR_BITS-1:3];
        end
        if (s_axil_wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    wr_state_d = WR_RESP;
                    bresp_d    = RESP_OKAY;
                    case (wr_sel)
                        SEL_CTRL: begin
                            ctrl_start_d = w_strb_q[0] & w_data_q[0];
                            ctrl_clear_d = w_strb_q[0] & w_data_q[1];
                        end
                        SEL_KEY0: key_d[0] = merge_bytes(key_q[0], w_data_q, w_strb_q);
                        SEL_KEY1: key_d[1] = merge_bytes(key_q[1], w_data_q, w_strb_q);
                        SEL_KEY2: key_d[2] = merge_bytes(key_q[2], w_data_q, w_strb_q);
                        SEL_KEY3: key_d[3] = merge_bytes(key_q[3], w_data_q, w_strb_q);
                        SEL_LEN: begin
                            for (int i = 0; i < 4; i++) begin
                                if (w_strb_q[i]) begin
                                    len_d[8*i +: 8] = w_data_q[8*i +: 8];
                                end
                            end
                        end
                        // Read-only and unmapped targets: discard the data.
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    wr_state_d = WR_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
    end

    // ------------------------------------------------------------------
    // Read FSM: data is captured at the AR handshake from the current
    // register values, so a concurrent write is seen only by later reads.
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d     = rd_state_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        rd_sel_d       = rd_sel_q;
        done_d         = done_q;
        status_rd_done = 1'b0;
        ar_sel         = decode(s_axil_araddr[ADDR_BITS-1:3]);

        case (rd_state_q)
            R_IDLE: begin
                if (s_axil_arvalid && arready_q) begin
                    rd_state_d = R_DATA;
                    rd_sel_d   = ar_sel;
                    rresp_d    = RESP_OKAY;
                    case (ar_sel)
                        SEL_STATUS: rdata_d = {{(DATA_BITS-2){1'b0}}, done_q, busy_i};
                        SEL_KEY0:   rdata_d = key_q[0];
                        SEL_KEY1:   rdata_d = key_q[1];
                        SEL_KEY2:   rdata_d = key_q[2];
                        SEL_KEY3:   rdata_d = key_q[3];
                        SEL_LEN:    rdata_d = {{(DATA_BITS-32){1'b0}}, len_q};
`ifdef HMAC_CTRL_STATS_EN
                        SEL_PKT:    rdata_d = {{(DATA_BITS-32){1'b0}}, pkt_cnt_q};
                        SEL_BCNT:   rdata_d = byte_cnt_q;
`endif
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rd_state_d     = R_IDLE;
                    status_rd_done = (rd_sel_q == SEL_STATUS);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // A new done pulse takes priority over the read-to-clear.
        if (status_rd_done) begin
            done_d = 1'b0;
        end
        if (done_i) begin
            done_d = 1'b1;
        end

        arready_d = (rd_state_d == R_IDLE);
    end

`ifdef HMAC_CTRL_STATS_EN
    // Clear is applied after the increment so it wins when both coincide.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (pkt_done_i) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            byte_cnt_d = byte_cnt_q + {48'd0, pkt_bytes_i};
        end
        if (ctrl_clear_q) begin
            pkt_cnt_d  = '0;
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{pkt_done_i, pkt_bytes_i};
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q   <= WR_IDLE;
            aw_held_q    <= 1'b0;
            aw_word_q    <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            ctrl_start_q <= 1'b0;
            ctrl_clear_q <= 1'b0;
            key_q        <= '0;
            len_q        <= '0;
            rd_state_q   <= R_IDLE;
            arready_q    <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rd_sel_q     <= SEL_NONE;
            done_q       <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            aw_held_q    <= aw_held_d;
            aw_word_q    <= aw_word_d;
            w_held_q     <= w_held_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bresp_q      <= bresp_d;
            ctrl_start_q <= ctrl_start_d;
            ctrl_clear_q <= ctrl_clear_d;
            key_q        <= key_d;
            len_q        <= len_d;
            rd_state_q   <= rd_state_d;
            arready_q    <= arready_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rd_sel_q     <= rd_sel_d;
            done_q       <= done_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_bvalid  = (wr_state_q == WR_RESP);
    assign s_axil_arready = arready_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rvalid  = (rd_state_q == R_DATA);
    assign ctrl_start     = ctrl_start_q;
    assign ctrl_clear     = ctrl_clear_q;
    assign key_o          = key_q;
    assign len_o          = len_q;

endmodule

// File: tb/tb_hmac_ctrl_slave.sv
// tb/tb_hmac_ctrl_slave.sv - directed self-checking bench for hmac_ctrl_slave
module tb_hmac_ctrl_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [63:0] s_axil_wdata;
    logic [7:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [15:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [63:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic        ctrl_start;
    logic        ctrl_clear;
    logic [255:0] key_o;
    logic [31:0] len_o;
    logic        busy_i;
    logic        done_i;
    logic        pkt_done_i;
    logic [15:0] pkt_bytes_i;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int clear_cnt = 0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (ctrl_start === 1'b1) start_cnt++;
        if (ctrl_clear === 1'b1) clear_cnt++;
    end

    hmac_ctrl_slave #(.ADDR_BITS(16), .DATA_BITS(64)) dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .ctrl_start(ctrl_start), .ctrl_clear(ctrl_clear), .key_o(key_o), .len_o(len_o),
        .busy_i(busy_i), .done_i(done_i), .pkt_done_i(pkt_done_i), .pkt_bytes_i(pkt_bytes_i)
    );

    // W is offered w_lead cycles before AW (0 = same cycle). lat counts
    // cycles from the last address/data handshake to bvalid.
    task automatic axi_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int w_lead, output logic [1:0] resp, output int lat,
                             output logic start_at_b);
        int t;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_done = 0; w_done = 0; t = 0;
        resp = 2'bxx; start_at_b = 1'bx;
        @(negedge aclk);
        s_axil_awaddr = addr;
        s_axil_wdata  = data;
        s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && t < 50) begin
            if (!w_done) s_axil_wvalid = 1'b1;
            if (!aw_done && t >= w_lead) s_axil_awvalid = 1'b1;
            aw_fire = s_axil_awvalid && s_axil_awready;
            w_fire  = s_axil_wvalid && s_axil_wready;
            @(posedge aclk);
            @(negedge aclk);
            if (aw_fire) begin aw_done = 1; s_axil_awvalid = 1'b0; end
            if (w_fire)  begin w_done = 1;  s_axil_wvalid = 1'b0; end
            t++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        t = 0;
        while (s_axil_bvalid !== 1'b1 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        lat = t;
        n_cmp++;
        if (s_axil_bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, s_axil_bvalid);
        end else begin
            resp = s_axil_bresp;
            start_at_b = ctrl_start;
            s_axil_bready = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            s_axil_bready = 1'b0;
        end
    endtask

    // Holds rready low for 'hold' cycles after rvalid; 'stable' reports whether
    // rvalid/rdata/rresp kept their first values throughout.
    task automatic axi_read(input logic [15:0] addr, input int hold, input bit done_at_hs,
                            output logic [63:0] data, output logic [1:0] resp, output bit stable);
        int t;
        bit fired, fire_now;
        fired = 0; t = 0; stable = 0;
        data = 'x; resp = 2'bxx;
        @(negedge aclk);
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!fired && t < 50) begin
            fire_now = s_axil_arready;
            @(posedge aclk);
            @(negedge aclk);
            if (fire_now) begin fired = 1; s_axil_arvalid = 1'b0; end
            t++;
        end
        s_axil_arvalid = 1'b0;
        t = 0;
        while (s_axil_rvalid !== 1'b1 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        n_cmp++;
        if (s_axil_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, s_axil_rvalid);
        end else begin
            data = s_axil_rdata;
            resp = s_axil_rresp;
            stable = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== data || s_axil_rresp !== resp) stable = 0;
            end
            s_axil_rready = 1'b1;
            if (done_at_hs) done_i = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            s_axil_rready = 1'b0;
            done_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got %b required 00000",
                     {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid});
        end
        n_cmp++;
        if (key_o !== 256'd0 || len_o !== 32'd0 || s_axil_rdata !== 64'd0) begin
            n_err++;
            $display("FAIL reset_regs: key=%h len=%h rdata=%h required 0", key_o, len_o, s_axil_rdata);
        end
        n_cmp++;
        if ({ctrl_start, ctrl_clear, s_axil_bresp, s_axil_rresp} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_pulses_resp: got %b required 000000",
                     {ctrl_start, ctrl_clear, s_axil_bresp, s_axil_rresp});
        end
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_exit_ready: got %b required 111",
                     {s_axil_awready, s_axil_wready, s_axil_arready});
        end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] resp; int lat; logic sab;
        axi_write(16'h0010, 64'h0123456789ABCDEF, 8'hFF, 0, resp, lat, sab);
        n_cmp++;
        if (resp !== 2'b00) begin n_err++; $display("FAIL key0_resp: got %b required 00", resp); end
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL key0_latency: got %0d required 1", lat); end
        n_cmp++;
        if (key_o[63:0] !== 64'h0123456789ABCDEF) begin
            n_err++; $display("FAIL key0_value: got %h required 0123456789abcdef", key_o[63:0]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat; logic sab; logic [63:0] d; bit st;
        axi_write(16'h0030, 64'hFFFF_FFFF_0000_0040, 8'h0F, 3, resp, lat, sab);
        n_cmp++;
        if (resp !== 2'b00 || len_o !== 32'h40) begin
            n_err++; $display("FAIL len_w_first: resp=%b len=%h required 00 / 00000040", resp, len_o);
        end
        axi_read(16'h0030, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'h40 || resp !== 2'b00) begin
            n_err++; $display("FAIL len_readback: got %h/%b required 0000000000000040/00", d, resp);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; int lat; logic sab;
        axi_write(16'h0018, 64'h1122334455667788, 8'h00, 0, resp, lat, sab);
        n_cmp++;
        if (resp !== 2'b00 || key_o[127:64] !== 64'd0) begin
            n_err++; $display("FAIL strb_zero: resp=%b key1=%h required 00 / 0", resp, key_o[127:64]);
        end
        axi_write(16'h0018, 64'h1122334455667788, 8'h81, 1, resp, lat, sab);
        n_cmp++;
        if (key_o[127:64] !== 64'h1100000000000088) begin
            n_err++; $display("FAIL strb_partial: got %h required 1100000000000088", key_o[127:64]);
        end
    endtask

    task automatic test_ctrl_pulse();
        logic [1:0] resp; int lat; logic sab; int s0, c0;
        s0 = start_cnt; c0 = clear_cnt;
        axi_write(16'h0000, 64'h1, 8'hFF, 0, resp, lat, sab);
        repeat (3) @(negedge aclk);
        n_cmp++;
        if (resp !== 2'b00 || sab !== 1'b1) begin
            n_err++; $display("FAIL ctrl_start_at_bvalid: resp=%b start=%b required 00 / 1", resp, sab);
        end
        n_cmp++;
        if (start_cnt - s0 !== 1 || clear_cnt - c0 !== 0) begin
            n_err++; $display("FAIL ctrl_start_width: start=%0d clear=%0d cycles required 1 / 0",
                              start_cnt - s0, clear_cnt - c0);
        end
    endtask

    task automatic test_read_hold();
        logic [63:0] d; logic [1:0] resp; bit st;
        axi_read(16'h0010, 5, 0, d, resp, st);
        n_cmp++;
        if (st !== 1'b1 || d !== 64'h0123456789ABCDEF || resp !== 2'b00) begin
            n_err++; $display("FAIL read_hold: stable=%b data=%h resp=%b required 1 / 0123456789abcdef / 00",
                              st, d, resp);
        end
        axi_read(16'h0013, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'h0123456789ABCDEF) begin
            n_err++; $display("FAIL addr_low_bits: got %h required 0123456789abcdef", d);
        end
    endtask

    task automatic test_done_sticky();
        logic [63:0] d; logic [1:0] resp; bit st;
        @(negedge aclk); done_i = 1'b1;
        @(negedge aclk); done_i = 1'b0;
        axi_read(16'h0008, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'h2) begin n_err++; $display("FAIL done_first_read: got %h required 2", d); end
        axi_read(16'h0008, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'h0) begin n_err++; $display("FAIL done_cleared: got %h required 0", d); end
        @(negedge aclk); done_i = 1'b1;
        @(negedge aclk); done_i = 1'b0;
        axi_read(16'h0008, 0, 1, d, resp, st);
        axi_read(16'h0008, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'h2) begin n_err++; $display("FAIL done_set_wins: got %h required 2", d); end
        axi_read(16'h0008, 0, 0, d, resp, st);
        busy_i = 1'b1;
        axi_read(16'h0008, 0, 0, d, resp, st);
        busy_i = 1'b0;
        n_cmp++;
        if (d !== 64'h1) begin n_err++; $display("FAIL status_busy: got %h required 1", d); end
    endtask

    task automatic test_errors();
        logic [63:0] d; logic [1:0] resp; int lat; logic sab; bit st;
        axi_write(16'h0008, 64'hFF, 8'hFF, 0, resp, lat, sab);
        n_cmp++;
        if (resp !== 2'b10) begin n_err++; $display("FAIL write_ro_resp: got %b required 10", resp); end
        axi_read(16'h0050, 0, 0, d, resp, st);
        n_cmp++;
        if (resp !== 2'b10 || d !== 64'd0) begin
            n_err++; $display("FAIL read_unmapped: got %b/%h required 10/0", resp, d);
        end
        axi_read(16'h0000, 0, 0, d, resp, st);
        n_cmp++;
        if (resp !== 2'b10 || d !== 64'd0) begin
            n_err++; $display("FAIL read_wo: got %b/%h required 10/0", resp, d);
        end
        axi_write(16'h0048, 64'hFF, 8'hFF, 0, resp, lat, sab);
        n_cmp++;
        if (resp !== 2'b10 || len_o !== 32'h40) begin
            n_err++; $display("FAIL write_unmapped: resp=%b len=%h required 10 / 40", resp, len_o);
        end
    endtask

    task automatic test_concurrent();
        logic [63:0] d;
        @(negedge aclk);
        s_axil_awaddr = 16'h0020; s_axil_awvalid = 1'b1;
        s_axil_wdata = 64'hCAFEF00D12345678; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        s_axil_araddr = 16'h0020; s_axil_arvalid = 1'b1; s_axil_bready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        s_axil_arvalid = 1'b0;
        d = s_axil_rdata;
        n_cmp++;
        if (s_axil_rvalid !== 1'b1 || d !== 64'd0 || s_axil_bvalid !== 1'b1) begin
            n_err++; $display("FAIL read_pre_write: rvalid=%b rdata=%h bvalid=%b required 1 / 0 / 1",
                              s_axil_rvalid, d, s_axil_bvalid);
        end
        @(posedge aclk); @(negedge aclk);
        s_axil_bready = 1'b0; s_axil_rready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        s_axil_rready = 1'b0;
        n_cmp++;
        if (key_o[191:128] !== 64'hCAFEF00D12345678 || s_axil_rvalid !== 1'b0 || s_axil_bvalid !== 1'b0) begin
            n_err++; $display("FAIL concurrent_write: key2=%h rvalid=%b bvalid=%b required cafef00d12345678 / 0 / 0",
                              key_o[191:128], s_axil_rvalid, s_axil_bvalid);
        end
    endtask

    task automatic test_reset_mid_txn();
        @(negedge aclk);
        s_axil_awaddr = 16'h0028; s_axil_awvalid = 1'b1;
        s_axil_wdata = 64'hDEAD; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        s_axil_bready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk); @(negedge aclk);
        areset = 1'b0;
        repeat (3) begin
            @(posedge aclk); @(negedge aclk);
            n_cmp++;
            if (s_axil_bvalid !== 1'b0) begin
                n_err++; $display("FAIL abort_no_b: bvalid=%b required 0", s_axil_bvalid);
            end
        end
        s_axil_bready = 1'b0;
        n_cmp++;
        if (key_o !== 256'd0 || len_o !== 32'd0 || s_axil_awready !== 1'b1) begin
            n_err++; $display("FAIL abort_state: key=%h len=%h awready=%b required 0 / 0 / 1",
                              key_o, len_o, s_axil_awready);
        end
    endtask

    task automatic test_stats();
        logic [63:0] d; logic [1:0] resp; bit st;
`ifdef HMAC_CTRL_STATS_EN
        @(negedge aclk); pkt_done_i = 1'b1; pkt_bytes_i = 16'd100;
        @(negedge aclk); pkt_bytes_i = 16'hFFFF;
        @(negedge aclk); pkt_done_i = 1'b0;
        axi_read(16'h0038, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'd2) begin n_err++; $display("FAIL pkt_cnt: got %h required 2", d); end
        axi_read(16'h0040, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'd65635) begin n_err++; $display("FAIL byte_cnt: got %0d required 65635", d); end
        @(negedge aclk);
        s_axil_awaddr = 16'h0000; s_axil_awvalid = 1'b1;
        s_axil_wdata = 64'h2; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        pkt_done_i = 1'b1; pkt_bytes_i = 16'd100;
        @(posedge aclk); @(negedge aclk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        n_cmp++;
        if (ctrl_clear !== 1'b1) begin n_err++; $display("FAIL clear_pulse: got %b required 1", ctrl_clear); end
        @(posedge aclk); @(negedge aclk);
        pkt_done_i = 1'b0; s_axil_bready = 1'b0;
        axi_read(16'h0038, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'd0) begin n_err++; $display("FAIL pkt_clear_wins: got %h required 0", d); end
        axi_read(16'h0040, 0, 0, d, resp, st);
        n_cmp++;
        if (d !== 64'd0) begin n_err++; $display("FAIL byte_clear_wins: got %h required 0", d); end
`else
        @(negedge aclk); pkt_done_i = 1'b1; pkt_bytes_i = 16'd100;
        @(negedge aclk); pkt_done_i = 1'b0;
        axi_read(16'h0038, 0, 0, d, resp, st);
        n_cmp++;
        if (resp !== 2'b10 || d !== 64'd0) begin
            n_err++; $display("FAIL pkt_cnt_unmapped: got %b/%h required 10/0", resp, d);
        end
        axi_read(16'h0040, 0, 0, d, resp, st);
        n_cmp++;
        if (resp !== 2'b10 || d !== 64'd0) begin
            n_err++; $display("FAIL byte_cnt_unmapped: got %b/%h required 10/0", resp, d);
        end
`endif
    endtask

    initial begin
        areset = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        busy_i = 1'b0; done_i = 1'b0; pkt_done_i = 1'b0; pkt_bytes_i = '0;

        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_strobes();
        test_ctrl_pulse();
        test_read_hold();
        test_done_sticky();
        test_errors();
        test_concurrent();
        test_reset_mid_txn();
        test_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
